// File: rtl/seq_alu_acc.sv
// Multi-cycle accumulator ALU with start/ready/done handshake; MUL/DIV iterate one bit per cycle.
// Define SEQ_ALU_FACT_EN to build the iterative factorial (op 4); otherwise op 4 is undefined.
module seq_alu_acc #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [4:0]           op,
   input  logic                 src_acc,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 ready,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 err,
   output logic [WIDTH-1:0]     acc
);

   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = (SH_W + 1 > 5) ? SH_W + 1 : 5;
   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

`ifdef SEQ_ALU_FACT_EN
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FACT} state_e;
`else
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
`endif

   typedef enum logic [4:0] {
      OP_CLR  = 5'd0,  OP_NOT = 5'd1,  OP_SHR = 5'd2,  OP_SHL = 5'd3,
      OP_FACT = 5'd4,  OP_ADD = 5'd6,  OP_SUB = 5'd7,  OP_MUL = 5'd8,
      OP_DIV  = 5'd9,  OP_AND = 5'd10, OP_OR  = 5'd11, OP_XOR = 5'd12
   } op_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   x_q, x_d;       // MUL multiplicand / FACT running product
   logic [2*WIDTH-1:0]   p_q, p_d;       // MUL partial product
   logic [WIDTH-1:0]     y_q, y_d;       // MUL multiplier / DIV quotient / FACT down-counter
   logic [WIDTH-1:0]     r_q, r_d;       // DIV partial remainder
   logic [WIDTH-1:0]     d_q, d_d;       // DIV divisor
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]     acc_q, acc_d;

   logic [WIDTH-1:0]     opx;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   p_nxt;
   logic [WIDTH:0]       shifted;
   logic                 ge;
   logic [WIDTH-1:0]     r_nxt, q_nxt;
   logic                 fin, fin_err;
   logic [2*WIDTH-1:0]   fin_res;
`ifdef SEQ_ALU_FACT_EN
   logic [3*WIDTH-1:0]   f_prod;
`endif

   assign opx     = src_acc ? acc_q : a;
   assign sum     = {1'b0, opx} + {1'b0, b};
   assign p_nxt   = y_q[0] ? p_q + x_q : p_q;
   assign shifted = {r_q, y_q[WIDTH-1]};
   assign ge      = shifted >= {1'b0, d_q};
   assign r_nxt   = ge ? shifted[WIDTH-1:0] - d_q : shifted[WIDTH-1:0];
   assign q_nxt   = {y_q[WIDTH-2:0], ge};
`ifdef SEQ_ALU_FACT_EN
   assign f_prod  = {{WIDTH{1'b0}}, x_q} * {{(2*WIDTH){1'b0}}, y_q};
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      p_d      = p_q;
      y_d      = y_q;
      r_d      = r_q;
      d_d      = d_q;
      done_d   = 1'b0;
      err_d    = err_q;
      result_d = result_q;
      acc_d    = acc_q;
      fin      = 1'b0;
      fin_err  = 1'b0;
      fin_res  = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op_e'(op))
                  OP_CLR: fin = 1'b1;
                  OP_NOT: begin
                     fin     = 1'b1;
                     fin_res = {{WIDTH{1'b0}}, ~opx};
                  end
                  OP_SHR: begin
                     fin     = 1'b1;
                     fin_res = {{WIDTH{1'b0}}, opx >> b[SH_W-1:0]};
                  end
                  OP_SHL: begin
                     fin     = 1'b1;
                     fin_res = {{WIDTH{1'b0}}, opx << b[SH_W-1:0]};
                  end
                  OP_ADD: begin
                     fin     = 1'b1;
                     fin_res = {{(WIDTH-1){1'b0}}, sum};
                     fin_err = sum[WIDTH];
                  end
                  OP_SUB: begin
                     fin     = 1'b1;
                     fin_res = {{WIDTH{1'b0}}, opx - b};
                     fin_err = opx < b;
                  end
                  OP_AND: begin
                     fin     = 1'b1;
                     fin_res = {{WIDTH{1'b0}}, opx & b};
                  end
                  OP_OR: begin
                     fin     = 1'b1;
                     fin_res = {{WIDTH{1'b0}}, opx | b};
                  end
                  OP_XOR: begin
                     fin     = 1'b1;
                     fin_res = {{WIDTH{1'b0}}, opx ^ b};
                  end
                  OP_MUL: begin
                     state_d = S_MUL;
                     cnt_d   = '0;
                     x_d     = {{WIDTH{1'b0}}, opx};
                     y_d     = b;
                     p_d     = '0;
                  end
                  OP_DIV: begin
                     if (b == '0) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                     end else begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                        y_d     = opx;
                        r_d     = '0;
                        d_d     = b;
                     end
                  end
`ifdef SEQ_ALU_FACT_EN
                  OP_FACT: begin
                     if (opx <= WIDTH'(1)) begin
                        fin     = 1'b1;
                        fin_res = {{(2*WIDTH-1){1'b0}}, 1'b1};
                     end else begin
                        state_d = S_FACT;
                        x_d     = {{(2*WIDTH-1){1'b0}}, 1'b1};
                        y_d     = opx;
                     end
                  end
`endif
                  default: begin
                     fin     = 1'b1;
                     fin_err = 1'b1;
                  end
               endcase
            end
         end
         S_MUL: begin
            p_d   = p_nxt;
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IT) begin
               fin     = 1'b1;
               fin_res = p_nxt;
            end
         end
         S_DIV: begin
            r_d   = r_nxt;
            y_d   = q_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IT) begin
               fin     = 1'b1;
               fin_res = {r_nxt, q_nxt};
            end
         end
`ifdef SEQ_ALU_FACT_EN
         // Overflow is judged on the full product before it is truncated into x_q.
         S_FACT: begin
            if (f_prod[3*WIDTH-1:2*WIDTH] != '0) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else if (y_q == WIDTH'(2)) begin
               fin     = 1'b1;
               fin_res = f_prod[2*WIDTH-1:0];
            end else begin
               x_d = f_prod[2*WIDTH-1:0];
               y_d = y_q - WIDTH'(1);
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      if (fin) begin
         state_d  = S_IDLE;
         done_d   = 1'b1;
         result_d = fin_res;
         err_d    = fin_err;
         if (!fin_err) acc_d = fin_res[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         x_q      <= '0;
         p_q      <= '0;
         y_q      <= '0;
         r_q      <= '0;
         d_q      <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         p_q      <= p_d;
         y_q      <= y_d;
         r_q      <= r_d;
         d_q      <= d_d;
         done_q   <= done_d;
         err_q    <= err_d;
         result_q <= result_d;
         acc_q    <= acc_d;
      end
   end

   assign ready  = (state_q == S_IDLE);
   assign done   = done_q;
   assign result = result_q;
   assign err    = err_q;
   assign acc    = acc_q;

endmodule

// File: tb/tb_seq_alu_acc.sv
// Randomized self-checking bench for seq_alu_acc against an arithmetic reference model.
// Honours SEQ_ALU_FACT_EN the same way the design does.
module tb_seq_alu_acc;

   localparam int W = 16;
   localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           start = 1'b0;
   logic [4:0]     op = '0;
   logic           src_acc = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           ready, done, err;
   logic [2*W-1:0] result;
   logic [W-1:0]   acc;

   int n_checks = 0;
   int n_errs   = 0;
   longint unsigned acc_m = 0;

   seq_alu_acc #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .src_acc(src_acc),
      .a(a), .b(b), .ready(ready), .done(done), .result(result), .err(err), .acc(acc)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input int opc, input longint unsigned x, input longint unsigned bv,
                                 output longint unsigned r, output bit e, output int lat);
      longint unsigned p;
      r = 0; e = 1'b0; lat = 1; p = 1;
      case (opc)
         0:  r = 0;
         1:  r = ~x & MASK;
         2:  r = x >> (bv % W);
         3:  r = (x << (bv % W)) & MASK;
         4: begin
`ifdef SEQ_ALU_FACT_EN
            if (x <= 1) r = 1;
            else begin
               for (longint unsigned k = x; k >= 2; k--) begin
                  p   = p * k;
                  lat = int'(x - k) + 2;
                  if ((p >> (2*W)) != 0) begin
                     e = 1'b1;
                     break;
                  end
               end
               r = e ? 0 : p;
            end
`else
            e = 1'b1;
`endif
         end
         6: begin r = x + bv; e = (r > MASK); end
         7: begin r = (x - bv) & MASK; e = (x < bv); end
         8: begin r = x * bv; lat = W + 1; end
         9: begin
            if (bv == 0) e = 1'b1;
            else begin r = ((x % bv) << W) | (x / bv); lat = W + 1; end
         end
         10: r = x & bv;
         11: r = x | bv;
         12: r = x ^ bv;
         default: e = 1'b1;
      endcase
   endfunction

   // Issues one op right away (so back-to-back starts land in the done cycle) and checks it.
   task automatic run_op(input int opc, input bit src, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit poke, input string tag);
      longint unsigned x, er;
      bit ee;
      int el, n;
      x = src ? acc_m : longint'(av);
      model(opc, x, longint'(bv), er, ee, el);
      check_val({tag, ":ready_idle"}, ready, 1);
      op = opc[4:0]; src_acc = src; a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      n = 1;
      start = 1'b0;
      while (!done && n < 100) begin
         check_val({tag, ":ready_busy"}, ready, 0);
         if (poke) begin
            start = 1'b1; op = 5'd6; src_acc = 1'b0; a = W'($urandom); b = W'($urandom);
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check_val({tag, ":done"}, done, 1);
      check_val({tag, ":latency"}, n, el);
      check_val({tag, ":result"}, result, er);
      check_val({tag, ":err"}, err, ee);
      if (!ee) acc_m = er & MASK;
      check_val({tag, ":acc"}, acc, acc_m);
      check_val({tag, ":ready_done"}, ready, 1);
   endtask

   initial begin : main
      int valid_ops[12] = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12};
      int opc;
      bit src, seen_done;
      logic [W-1:0] av, bv;

      repeat (2) @(posedge clk);
      #1;
      check_val("rst:ready", ready, 1);
      check_val("rst:done", done, 0);
      check_val("rst:result", result, 0);
      check_val("rst:err", err, 0);
      check_val("rst:acc", acc, 0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      run_op(6, 0, 16'hFFFF, 16'h0002, 0, "add_carry");
      check_val("add_carry:const", result, 32'h0001_0001);
      run_op(6, 0, 16'd2, 16'd20, 0, "add");
      check_val("add:acc_const", acc, 22);
      run_op(7, 1, 16'd0, 16'd30, 0, "sub_acc");
      check_val("sub_acc:const", result, 32'h0000_FFF8);
      run_op(3, 1, 16'd0, 16'd3, 0, "shl_acc");
      check_val("shl_acc:const", acc, 176);
      run_op(2, 1, 16'd0, 16'd4, 0, "shr_acc");
      run_op(0, 0, 16'h1234, 16'h5678, 0, "clr");
      run_op(8, 0, 16'd300, 16'd500, 1, "mul_poke");
      check_val("mul:const", result, 32'h0002_49F0);
      run_op(9, 0, 16'd1000, 16'd7, 0, "div_b2b");
      check_val("div:const", result, 32'h0006_008E);
      run_op(9, 0, 16'd1000, 16'd0, 0, "div0");
      run_op(8, 0, 16'hFFFF, 16'hFFFF, 0, "mul_max");
      run_op(9, 0, 16'hFFFF, 16'd1, 0, "div_by1");
      run_op(4, 0, 16'd8, 16'd0, 0, "fact8");
      run_op(4, 0, 16'd13, 16'd0, 0, "fact13");
      run_op(4, 0, 16'd1, 16'd0, 0, "fact1");
      run_op(5, 0, 16'd3, 16'd4, 0, "undef5");
      run_op(31, 0, 16'd3, 16'd4, 0, "undef31");

      for (int i = 0; i < 150; i++) begin
         case ($urandom % 16)
            0:       opc = int'($urandom_range(13, 31));
            1:       opc = 5;
            default: opc = valid_ops[$urandom % 12];
         endcase
         av  = W'($urandom);
         bv  = W'($urandom);
         src = 1'($urandom % 2);
         if (opc == 4) begin
            src = 1'b0;
            av  = W'($urandom_range(0, 14));
         end
         if (opc == 9 && ($urandom % 5) == 0) bv = '0;
         run_op(opc, src, av, bv, 1'($urandom % 2), "rand");
         if (($urandom % 4) == 0) begin
            @(posedge clk); #1;
            check_val("rand:done_pulse", done, 0);
         end
      end

      // Abort a MUL in its 5th cycle with a nonzero accumulator.
      run_op(6, 0, 16'd5, 16'd6, 0, "pre_rst");
      op = 5'd8; src_acc = 1'b0; a = 16'd300; b = 16'd500; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_val("midrst:ready", ready, 1);
      check_val("midrst:done", done, 0);
      check_val("midrst:result", result, 0);
      check_val("midrst:err", err, 0);
      check_val("midrst:acc", acc, 0);
      acc_m = 0;
      seen_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      check_val("midrst:no_done", seen_done, 0);
      check_val("midrst:ready_after", ready, 1);
      check_val("midrst:result_after", result, 0);
      run_op(6, 0, 16'd2, 16'd20, 0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/seq_alu_acc.md
# seq_alu_acc

Parametrised, multi-cycle accumulator ALU: successor to the 16-bit combinational ALU. Width is set by a parameter. MUL and DIV are iterative. The accumulator is an internal register, so the separate acc operand port and duplicated opcodes are gone: one `src_acc` bit selects the first operand instead. A start/ready/done handshake serialises operations for the calculator datapath.

## Interface
- `WIDTH`, 16: operand width; result is 2*WIDTH; must be ≥4 and a power of two.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; accepted only on an edge where `ready`=1.
- `op` in 5: opcode, sampled at acceptance.
- `src_acc` in 1: 1 = first operand is `acc`, 0 = `a`; sampled at acceptance.
- `a` in WIDTH: first operand, sampled at acceptance.
- `b` in WIDTH: second operand, sampled at acceptance.
- `ready` out 1: idle; high combinationally in IDLE.
- `done` out 1: one-cycle pulse; `result`/`err` valid and held until next done.
- `result` out 2*WIDTH: operation result.
- `err` out 1: error flag for the last operation.
- `acc` out WIDTH: accumulator register.

## Operation
- Opcodes (X = selected first operand):
  - 0 CLR: result, err, acc ← 0.
  - 1 NOT: ~X.
  - 2 SHR: X >> b[log2(WIDTH)-1:0], logical.
  - 3 SHL: X << b[log2(WIDTH)-1:0], truncated to WIDTH.
  - 4 FACT: see Configuration.
  - 6 ADD: zero-extended X+b; err = carry-out.
  - 7 SUB: (X−b) mod 2^WIDTH; err = (X<b).
  - 8 MUL: full 2*WIDTH product, shift-add, one bit per cycle.
  - 9 DIV: restoring divide; result = {remainder, quotient}.
  - 10 AND, 11 OR, 12 XOR: bitwise X op b.
  - 5, 13–31: undefined; err=1, result=0.
- Width rule: all WIDTH-bit results are zero-extended into `result`.
- DIV with b=0: no iteration; err=1, result=0, latency 1.
- Accumulator:
  - On every done with err=0, acc ← result[WIDTH-1:0].
  - On done with err=1, acc is unchanged.
  - CLR always zeroes acc.
- States and transitions:
  - IDLE → MUL, DIV or FACT on acceptance of an iterative op.
  - IDLE → IDLE (done raised) for single-cycle ops, CLR, undefined ops, DIV-by-0, and FACT with X≤1.
  - MUL/DIV: 5-bit-plus iteration counter counts WIDTH iterations, then → IDLE with done.
  - FACT: runs while its down-counter i>1, then → IDLE with done.
- `start` while `ready`=0 is ignored; there is no queueing.
- Reset mid-operation: the in-flight op is discarded; no done is raised.
- Reset values: state IDLE, ready=1, done=0, result=0, err=0, acc=0.

## Timing
- Latency L: the L-th rising edge, counting the accepting edge as 1, registers done=1. Done is visible the following cycle.
- L=1: logic, shift, ADD, SUB, CLR, undefined ops, DIV-by-0.
- L=WIDTH+1: MUL and DIV (17 at WIDTH=16).
- FACT: L = X for X≥2; L=1 for X≤1.
- `ready` is high in the done cycle, so a new start may be accepted there (back-to-back ops). `ready` is low on every other cycle of an iterative op.
- `result`, `err` and `acc` update on the same edge that sets done.
- Deasserting `reset_n` takes effect immediately (asynchronous). Release is synchronous to the next `clk`.

## Configuration
- Macro `SEQ_ALU_FACT_EN`:
  - Defined: op 4 = X!, computed iteratively with one WIDTH×2*WIDTH multiply per cycle.
    - Product starts at 1; multiply by X, X−1, …, 2.
    - If any product exceeds 2*WIDTH bits: stop on that edge, raise done, err=1, result=0.
  - Not defined: op 4 behaves as undefined (err=1, result=0, L=1); no FACT state or multiplier is built.

## Test plan
- Reset: assert reset_n=0 in the 5th cycle of a MUL → all outputs at reset values immediately, no done ever; after release, ready=1.
- ADD: a=0xFFFF, b=0x0002 → done at L=1, result=0x0001_0001, err=1, acc unchanged. Then a=2, b=20 → result=22, acc=22.
- MUL: a=300, b=500 → done exactly at L=17, result=0x0002_49F0. Second start asserted in cycles 2–16 is ignored. A start in the done cycle is accepted.
- DIV:
  - a=1000, b=7 → L=17, result=0x0006_008E, err=0.
  - b=0 → L=1, err=1, result=0.
- Accumulator chain from acc=22:
  - src_acc=1, SUB b=30 → result=0xFFF8, err=1, acc=22.
  - src_acc=1, SHL b=3 → result=176, acc=176.
  - CLR → acc=0.
- FACT (macro on):
  - a=8 → L=8, result=40320.
  - a=13 → err=1, result=0 at L=13.
- FACT (macro off): op 4 → err=1, result=0 at L=1.
